// File: rtl/servo_ramp_ctrl.sv
// Two-channel servo duty ramp controller.
// Accepts duty commands between frame boundaries and slews each channel's
// PWM duty toward its clamped target by at most 'step' once per frame.
module servo_ramp_ctrl #(
  parameter int FRAME_LEN = 20000,
  parameter int DUTY_MIN  = 500,
  parameter int DUTY_MAX  = 2500,
  parameter int DUTY_INIT = 1500
) (
  input  logic        clk_1m,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_ch,
  input  logic [11:0] cmd_target,
  input  logic [7:0]  cmd_step,
  output logic [11:0] pwm_duty0,
  output logic [11:0] pwm_duty1,
  output logic [1:0]  busy,
  output logic [1:0]  done,
  output logic        frame_tick
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  localparam logic [14:0] CNT_LAST = 15'(FRAME_LEN - 1);
  localparam logic [11:0] D_MIN    = 12'(DUTY_MIN);
  localparam logic [11:0] D_MAX    = 12'(DUTY_MAX);
  localparam logic [11:0] D_INIT   = 12'(DUTY_INIT);

  logic [14:0] cnt_q, cnt_d;
  logic        accept;
  logic [11:0] target_clamped;

  // Frame counter wraps at FRAME_LEN-1 so it stays in phase with the PWM generator.
  always_comb begin
    cnt_d = cnt_q + 15'd1;
    if (frame_tick) begin
      cnt_d = '0;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk_1m or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The update edge is reserved for duty changes, so commands wait one cycle.
  assign frame_tick = (cnt_q == CNT_LAST);
  assign cmd_ready  = ~frame_tick;
  assign accept     = cmd_valid & cmd_ready;

  // Clamp the requested duty into the legal servo range.
  always_comb begin
    target_clamped = cmd_target;
    if (cmd_target < D_MIN) begin
      target_clamped = D_MIN;
    end else if (cmd_target > D_MAX) begin
      target_clamped = D_MAX;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    localparam logic CH = 1'(gi);

    state_t      state_q, state_d;
    logic [11:0] duty_q, duty_d;
    logic [11:0] target_q, target_d;
    logic [7:0]  step_q, step_d;
    logic        done_q, done_d;
    logic        up;
    logic [12:0] diff;

    // Distance to target in 13 bits so the comparison against step cannot wrap.
    always_comb begin
      up   = (target_q > duty_q);
      diff = up ? ({1'b0, target_q} - {1'b0, duty_q})
                : ({1'b0, duty_q} - {1'b0, target_q});
    end

    // Command capture and per-frame ramp step; a new command overrides any ramp in flight.
    always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      target_d = target_q;
      step_d   = step_q;
      done_d   = 1'b0;
      if (accept && (cmd_ch == CH)) begin
        target_d = target_clamped;
        step_d   = cmd_step;
        state_d  = (target_clamped != duty_q) ? ST_RAMP : ST_IDLE;
      end else if (frame_tick && (state_q == ST_RAMP)) begin
        if ((step_q == 8'd0) || (diff <= {5'd0, step_q})) begin
          duty_d  = target_q;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (up) begin
          duty_d = duty_q + {4'd0, step_q};
        end else begin
          duty_d = duty_q - {4'd0, step_q};
        end
      end
    end

    // Channel state registers; reset aborts any ramp without signalling done.
    always_ff @(posedge clk_1m or posedge rst) begin
      if (rst) begin
        state_q  <= ST_IDLE;
        duty_q   <= D_INIT;
        target_q <= D_INIT;
        step_q   <= 8'd0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        duty_q   <= duty_d;
        target_q <= target_d;
        step_q   <= step_d;
        done_q   <= done_d;
      end
    end

    assign busy[gi] = (state_q == ST_RAMP);
    assign done[gi] = done_q;
  end

  assign pwm_duty0 = g_ch[0].duty_q;
  assign pwm_duty1 = g_ch[1].duty_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed testbench for servo_ramp_ctrl with a short frame for fast runs.
module tb_servo_ramp_ctrl;

  localparam int FL = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_ch;
  logic [11:0] cmd_target;
  logic [7:0]  cmd_step;
  logic [11:0] pwm_duty0;
  logic [11:0] pwm_duty1;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic        frame_tick;

  int compared   = 0;
  int mismatched = 0;

  servo_ramp_ctrl #(
    .FRAME_LEN(FL), .DUTY_MIN(500), .DUTY_MAX(2500), .DUTY_INIT(1500)
  ) dut (
    .clk_1m(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_step(cmd_step),
    .pwm_duty0(pwm_duty0), .pwm_duty1(pwm_duty1), .busy(busy), .done(done),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Wait (from a negedge) for the next frame_tick, then to the negedge after its update edge.
  task automatic wait_tick();
    int n = 0;
    while (frame_tick !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (frame_tick !== 1'b1) begin
      compared++; mismatched++;
      $display("FAIL wait_tick: frame_tick=%b required 1 within 200 cycles", frame_tick);
    end
    @(negedge clk);
  endtask

  // Present one command from a negedge and hold it until accepted.
  task automatic send_cmd(input logic ch, input int tgt, input int step);
    int n = 0;
    cmd_valid = 1'b1; cmd_ch = ch; cmd_target = 12'(tgt); cmd_step = 8'(step);
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd ch%0d target=%0d step=%0d", ch, tgt, step);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = 1'b0; cmd_target = '0; cmd_step = '0;
    repeat (3) @(negedge clk);
    compared += 6;
    if (pwm_duty0 !== 12'd1500) begin mismatched++; $display("FAIL reset_duty0: got %0d required 1500", pwm_duty0); end
    if (pwm_duty1 !== 12'd1500) begin mismatched++; $display("FAIL reset_duty1: got %0d required 1500", pwm_duty1); end
    if (busy !== 2'b00) begin mismatched++; $display("FAIL reset_busy: got %b required 00", busy); end
    if (done !== 2'b00) begin mismatched++; $display("FAIL reset_done: got %b required 00", done); end
    if (frame_tick !== 1'b0) begin mismatched++; $display("FAIL reset_tick: got %b required 0", frame_tick); end
    if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
    $display("reset: duty0=%0d duty1=%0d busy=%b done=%b", pwm_duty0, pwm_duty1, busy, done);
    rst = 1'b0;
  endtask

  task automatic test_frame();
    int n = 0;
    int m = 1;
    while (frame_tick !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    compared++;
    if (n != FL - 1) begin mismatched++; $display("FAIL first_tick: after %0d cycles required %0d", n, FL - 1); end
    compared++;
    if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL ready_on_tick: got %b required 0", cmd_ready); end
    @(negedge clk);
    while (frame_tick !== 1'b1 && m < 200) begin @(negedge clk); m++; end
    compared++;
    if (m != FL) begin mismatched++; $display("FAIL tick_period: got %0d required %0d", m, FL); end
    @(negedge clk);
    compared += 3;
    if (pwm_duty0 !== 12'd1500) begin mismatched++; $display("FAIL idle_duty0: got %0d required 1500", pwm_duty0); end
    if (pwm_duty1 !== 12'd1500) begin mismatched++; $display("FAIL idle_duty1: got %0d required 1500", pwm_duty1); end
    if (busy !== 2'b00) begin mismatched++; $display("FAIL idle_busy: got %b required 00", busy); end
    $display("frame: first tick at %0d, period %0d", n, m);
  endtask

  task automatic test_ramp();
    int exp_duty [4] = '{1530, 1560, 1590, 1600};
    send_cmd(1'b0, 1600, 30);
    compared++;
    if (busy !== 2'b01) begin mismatched++; $display("FAIL ramp_busy_start: got %b required 01", busy); end
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      compared += 3;
      if (pwm_duty0 !== 12'(exp_duty[i])) begin mismatched++; $display("FAIL ramp_duty0[%0d]: got %0d required %0d", i, pwm_duty0, exp_duty[i]); end
      if (busy[0] !== (i < 3)) begin mismatched++; $display("FAIL ramp_busy[%0d]: got %b required %b", i, busy[0], (i < 3)); end
      if (done[0] !== (i == 3)) begin mismatched++; $display("FAIL ramp_done[%0d]: got %b required %b", i, done[0], (i == 3)); end
      $display("ramp tick %0d: duty0=%0d busy=%b done=%b", i, pwm_duty0, busy, done);
    end
    @(negedge clk);
    compared++;
    if (done !== 2'b00) begin mismatched++; $display("FAIL ramp_done_width: got %b required 00", done); end
  endtask

  task automatic test_clamp();
    send_cmd(1'b1, 3000, 0);
    wait_tick();
    compared += 3;
    if (pwm_duty1 !== 12'd2500) begin mismatched++; $display("FAIL clamp_hi: got %0d required 2500", pwm_duty1); end
    if (done !== 2'b10) begin mismatched++; $display("FAIL clamp_hi_done: got %b required 10", done); end
    if (pwm_duty0 !== 12'd1600) begin mismatched++; $display("FAIL clamp_other: got %0d required 1600", pwm_duty0); end
    $display("clamp hi: duty1=%0d done=%b", pwm_duty1, done);
    send_cmd(1'b1, 100, 0);
    wait_tick();
    compared += 2;
    if (pwm_duty1 !== 12'd500) begin mismatched++; $display("FAIL clamp_lo: got %0d required 500", pwm_duty1); end
    if (done !== 2'b10) begin mismatched++; $display("FAIL clamp_lo_done: got %b required 10", done); end
    $display("clamp lo: duty1=%0d done=%b", pwm_duty1, done);
  endtask

  task automatic test_tick_hold();
    int n = 0;
    while (frame_tick !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_ch = 1'b0; cmd_target = 12'd1700; cmd_step = 8'd0;
    @(negedge clk);
    compared += 2;
    if (busy[0] !== 1'b0) begin mismatched++; $display("FAIL hold_not_taken: busy0=%b required 0", busy[0]); end
    if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL hold_ready: got %b required 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    compared += 2;
    if (busy[0] !== 1'b1) begin mismatched++; $display("FAIL hold_taken: busy0=%b required 1", busy[0]); end
    if (pwm_duty0 !== 12'd1600) begin mismatched++; $display("FAIL hold_no_change: got %0d required 1600", pwm_duty0); end
    wait_tick();
    compared += 2;
    if (pwm_duty0 !== 12'd1700) begin mismatched++; $display("FAIL hold_duty0: got %0d required 1700", pwm_duty0); end
    if (done !== 2'b01) begin mismatched++; $display("FAIL hold_done: got %b required 01", done); end
    $display("tick hold: duty0=%0d done=%b", pwm_duty0, done);
  endtask

  task automatic test_retarget();
    int exp_duty [6] = '{1750, 1800, 1700, 1600, 1500, 1400};
    send_cmd(1'b0, 2000, 50);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        send_cmd(1'b0, 1400, 100);
      end
      wait_tick();
      compared += 2;
      if (pwm_duty0 !== 12'(exp_duty[i])) begin mismatched++; $display("FAIL retarget_duty0[%0d]: got %0d required %0d", i, pwm_duty0, exp_duty[i]); end
      if (done[0] !== (i == 5)) begin mismatched++; $display("FAIL retarget_done[%0d]: got %b required %b", i, done[0], (i == 5)); end
      $display("retarget tick %0d: duty0=%0d busy=%b done=%b", i, pwm_duty0, busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic saw_done = 1'b0;
    send_cmd(1'b0, 2500, 10);
    send_cmd(1'b1, 2000, 10);
    wait_tick();
    compared++;
    if (busy !== 2'b11) begin mismatched++; $display("FAIL mid_busy_pre: got %b required 11", busy); end
    #2 rst = 1'b1;
    #1;
    compared += 4;
    if (pwm_duty0 !== 12'd1500) begin mismatched++; $display("FAIL mid_duty0: got %0d required 1500", pwm_duty0); end
    if (pwm_duty1 !== 12'd1500) begin mismatched++; $display("FAIL mid_duty1: got %0d required 1500", pwm_duty1); end
    if (busy !== 2'b00) begin mismatched++; $display("FAIL mid_busy: got %b required 00", busy); end
    if (done !== 2'b00) begin mismatched++; $display("FAIL mid_done: got %b required 00", done); end
    @(negedge clk);
    rst = 1'b0;
    while (frame_tick !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (done !== 2'b00) saw_done = 1'b1;
    end
    @(negedge clk);
    if (done !== 2'b00) saw_done = 1'b1;
    compared += 3;
    if (n != FL - 1) begin mismatched++; $display("FAIL mid_restart: tick after %0d required %0d", n, FL - 1); end
    if (saw_done !== 1'b0) begin mismatched++; $display("FAIL mid_no_done: saw done=1 required none"); end
    if (pwm_duty0 !== 12'd1500) begin mismatched++; $display("FAIL mid_hold0: got %0d required 1500", pwm_duty0); end
    $display("reset mid-ramp: duty0=%0d duty1=%0d busy=%b restart=%0d", pwm_duty0, pwm_duty1, busy, n);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ramp();
    test_clamp();
    test_tick_hold();
    test_retarget();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/servo_ramp_ctrl.md
SERVO_RAMP_CTRL -- requirements
Module: servo_ramp_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 20000: PWM frame length in clk_1m cycles (20 ms).
REQ-002 Parameter DUTY_MIN, default 500: lowest legal duty, in cycles.
REQ-003 Parameter DUTY_MAX, default 2500: highest legal duty, in cycles.
REQ-004 Parameter DUTY_INIT, default 1500: duty (servo centre) after reset.
REQ-005 clk_1m  in  1  the single clock, 1 MHz; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid  in  1  command present.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-009 cmd_ch  in  1  target channel (0 or 1).
REQ-010 cmd_target  in  12  requested duty, unsigned cycles.
REQ-011 cmd_step  in  8  maximum duty change per frame; 0 means jump.
REQ-012 pwm_duty0  out  12  channel 0 duty, drives the servo PWM generator.
REQ-013 pwm_duty1  out  12  channel 1 duty.
REQ-014 busy  out  2  bit n high while channel n is ramping.
REQ-015 done  out  2  bit n pulses for one cycle when channel n reaches its target.
REQ-016 frame_tick  out  1  high for one cycle when the frame counter equals FRAME_LEN-1.

Function
REQ-017 A 15-bit frame counter SHALL count 0..FRAME_LEN-1 and wrap to 0, matching the phase of the PWM generator's counter.
REQ-018 frame_tick SHALL be combinational from the counter value (cnt == FRAME_LEN-1).
REQ-019 cmd_ready SHALL equal NOT frame_tick; no command is accepted on the update cycle.
REQ-020 On acceptance, the target SHALL be clamped to [DUTY_MIN, DUTY_MAX] and stored with cmd_step for channel cmd_ch; the other channel SHALL be unaffected.
REQ-021 Each channel SHALL have states IDLE and RAMP; acceptance with clamped target != current duty -> RAMP, otherwise stay/return IDLE with no done pulse.
REQ-022 A command accepted while in RAMP SHALL replace target and step; the ramp continues from the current duty; the abandoned target produces no done.
REQ-023 Duty outputs SHALL change only on the rising edge where frame_tick is high; never mid-frame.
REQ-024 At that edge, per channel in RAMP: if step == 0 or |target - duty| <= step, then duty <= target, state -> IDLE, done bit = 1 for that one following cycle; else duty moves toward target by step.
REQ-025 Difference and step arithmetic SHALL use at least 13 bits; duty SHALL never overshoot the target or leave [DUTY_MIN, DUTY_MAX].
REQ-026 busy[n] SHALL be 1 exactly while channel n is in RAMP; done and busy SHALL never be high together for the same channel.
REQ-027 Both channels SHALL update independently on the same frame_tick edge.
REQ-028 First duty change after acceptance SHALL occur at the next frame_tick edge (latency 1..FRAME_LEN cycles).

Reset
REQ-029 While rst is high: counter = 0, pwm_duty0 = pwm_duty1 = DUTY_INIT, targets = DUTY_INIT, steps = 0, both states IDLE, busy = 0, done = 0; frame_tick is therefore 0 and cmd_ready is 1.
REQ-030 Reset asserted mid-ramp SHALL abort the ramp immediately with no done pulse; after release, the counter restarts from 0.

Verification
REQ-031 Reset release, no commands -> pwm_duty0/1 stay 1500; frame_tick pulses every 20000 cycles; busy = 00.
REQ-032 ch0 target 1600, step 30 -> duty 1530, 1560, 1590, 1600 on four successive ticks; done[0] pulses once after 1600; busy[0] is high until then.
REQ-033 ch1 target 3000, step 0 -> clamped; pwm_duty1 = 2500 at next tick; done[1] pulses; ch1 target 100 -> 500.
REQ-034 cmd_valid held across the frame_tick cycle -> not accepted that cycle; accepted the next cycle; no duty change until the following tick.
REQ-035 ch0 ramping to 2000 step 50 is retargeted to 1400 step 100 mid-ramp -> ramp reverses from the current duty; single done pulse at 1400 only.
REQ-036 rst pulsed mid-ramp on both channels -> both duties are 1500 asynchronously; busy = 00; no done pulse.
